rom_bank_burst_reader: RTL and testbench

//  Parametrised multi-bank ROM with a registered burst-read sequencer. NUM_BANKS sub-ROMs of

---
 rtl/rom_bank_burst_reader_if.sv | 38 +++
 rtl/rom_bank_burst_reader.sv | 156 +++++++++++++++
 tb/tb_rom_bank_burst_reader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/rom_bank_burst_reader_if.sv
// Bus bundle for rom_bank_burst_reader: start command, consumer handshake and read-data return.
// The parity signal exists only when ROM_PARITY_EN is defined.
interface rom_bank_burst_reader_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 5,
   parameter int LW    = 4
);
   logic             cs;
   logic             start;
   logic [AW-1:0]    start_addr;
   logic [LW-1:0]    burst_len;
   logic             ready;
   logic [WIDTH-1:0] datab;
   logic [AW-1:0]    addrb_out;
   logic             valid;
   logic             busy;
   logic             done;
   logic             err;
`ifdef ROM_PARITY_EN
   logic             parity;
`endif

   modport master (
      output cs, start, start_addr, burst_len, ready,
      input  datab, addrb_out, valid, busy, done, err
`ifdef ROM_PARITY_EN
      , input parity
`endif
   );

   modport slave (
      input  cs, start, start_addr, burst_len, ready,
      output datab, addrb_out, valid, busy, done, err
`ifdef ROM_PARITY_EN
      , output parity
`endif
   );
endinterface

// File: rtl/rom_bank_burst_reader.sv
// Multi-bank constant ROM with a registered burst-read sequencer on a valid/ready stream.
// Define ROM_PARITY_EN to add an even-parity bit registered alongside datab.
module rom_bank_burst_reader #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int NUM_BANKS = 3,
   parameter int LW        = 4,
   parameter int BASE      = 128,
   parameter int STEP      = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   rom_bank_burst_reader_if.slave  bus
);
   localparam int TOTAL = NUM_BANKS * DEPTH;
   localparam int AW    = $clog2(TOTAL);
   localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int IW    = $clog2(DEPTH);
   localparam int RW    = LW + 1;

   typedef enum logic {IDLE, READ} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    addr_q, addr_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [RW-1:0]    rem_q, rem_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
`ifdef ROM_PARITY_EN
   logic             parity_q;
`endif

   logic [AW-1:0]    addr_nxt;
   logic [AW-1:0]    rd_addr;
   logic [BW-1:0]    rd_bank;
   logic [IW-1:0]    rd_idx;
   logic [WIDTH-1:0] rom_rd;
   logic [WIDTH-1:0] bank_rd [NUM_BANKS];
   logic             start_ok;
   logic [RW-1:0]    len_load;

   function automatic logic [WIDTH-1:0] word_at(input int unsigned a);
      logic [31:0] w;
      w = 32'(BASE) + 32'(a) * 32'(STEP);
      return w[WIDTH-1:0];
   endfunction

   // Linear address space wraps at TOTAL, which need not be a power of two.
   assign addr_nxt = (addr_q == AW'(TOTAL - 1)) ? '0 : addr_q + AW'(1);
   assign rd_addr  = (state_q == IDLE) ? bus.start_addr : addr_nxt;
   assign rd_bank  = BW'(32'(rd_addr) / 32'(DEPTH));
   assign rd_idx   = IW'(32'(rd_addr) % 32'(DEPTH));
   assign start_ok = ({1'b0, bus.start_addr} < (AW + 1)'(TOTAL));
   assign len_load = (bus.burst_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, bus.burst_len};

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic [WIDTH-1:0] table_rd;
      always_comb begin
         table_rd = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IW'(i)) table_rd = word_at(b * DEPTH + i);
         end
      end
      assign bank_rd[b] = table_rd;
   end

   always_comb begin
      rom_rd = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (rd_bank == BW'(b)) rom_rd = bank_rd[b];
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no branch can leave one unassigned and infer a latch.
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      valid_d = valid_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.cs && bus.start) begin
               if (start_ok) begin
                  state_d = READ;
                  addr_d  = rd_addr;
                  data_d  = rom_rd;
                  valid_d = 1'b1;
                  rem_d   = len_load;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         READ: begin
            if (!bus.cs) begin
               state_d = IDLE;
               data_d  = '0;
               valid_d = 1'b0;
            end else if (bus.ready) begin
               if (rem_q == RW'(1)) begin
                  state_d = IDLE;
                  data_d  = '0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  rem_d  = rem_q - RW'(1);
                  addr_d = rd_addr;
                  data_d = rom_rd;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         rem_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef ROM_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         rem_q    <= rem_d;
         done_q   <= done_d;
         err_q    <= err_d;
`ifdef ROM_PARITY_EN
         parity_q <= ^data_d;
`endif
      end
   end

   assign bus.datab     = data_q;
   assign bus.addrb_out = addr_q;
   assign bus.valid     = valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
`ifdef ROM_PARITY_EN
   assign bus.parity    = parity_q;
`endif
endmodule

// File: tb/tb_rom_bank_burst_reader.sv
// Self-checking bench for rom_bank_burst_reader: directed vector table, corner-case sequences,
// and randomized traffic against a burst-level reference model.
module tb_rom_bank_burst_reader;
   localparam int TOTAL = 24;
   localparam int LW    = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   rom_bank_burst_reader_if #(.WIDTH(8), .AW(5), .LW(LW)) bus ();

   rom_bank_burst_reader #(
      .WIDTH(8), .DEPTH(8), .NUM_BANKS(3), .LW(LW), .BASE(128), .STEP(10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      bit cs;
      bit start;
      int addr;
      int len;
      bit ready;
      bit e_valid;
      int e_data;
      int e_addr;
      bit e_done;
      bit e_err;
   } vec_t;

   int n_tests  = 0;
   int n_failed = 0;

   // Reference model state: burst start, length and words accepted so far.
   bit m_act = 1'b0;
   int m_s   = 0;
   int m_len = 0;
   int m_k   = 0;

   function automatic int word(input int a);
      return (128 + a * 10) % 256;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_failed++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit cs, input bit start, input int addr, input int len, input bit ready);
      bus.cs         = cs;
      bus.start      = start;
      bus.start_addr = 5'(addr);
      bus.burst_len  = 4'(len);
      bus.ready      = ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input bit ev, input int ed, input int ea,
                            input bit edn, input bit eer);
      logic [7:0] ed8;
      ed8 = 8'(ed);
      check({tag, ".valid"}, 32'(bus.valid), 32'(ev));
      check({tag, ".busy"},  32'(bus.busy),  32'(ev));
      check({tag, ".datab"}, 32'(bus.datab), 32'(ed8));
      check({tag, ".done"},  32'(bus.done),  32'(edn));
      check({tag, ".err"},   32'(bus.err),   32'(eer));
      if (ev) check({tag, ".addrb"}, 32'(bus.addrb_out), 32'(ea));
`ifdef ROM_PARITY_EN
      check({tag, ".parity"}, 32'(bus.parity), 32'(^ed8));
`endif
   endtask

   task automatic model_step(input bit rst, input bit cs, input bit start, input int addr,
                             input int len, input bit ready,
                             output bit ev, output int ed, output int ea,
                             output bit edn, output bit eer);
      edn = 1'b0;
      eer = 1'b0;
      if (rst) begin
         m_act = 1'b0;
      end else if (m_act) begin
         if (!cs) begin
            m_act = 1'b0;
         end else if (ready) begin
            m_k++;
            if (m_k == m_len) begin
               m_act = 1'b0;
               edn   = 1'b1;
            end
         end
      end else if (cs && start) begin
         if (addr < TOTAL) begin
            m_act = 1'b1;
            m_s   = addr;
            m_len = (len == 0) ? (1 << LW) : len;
            m_k   = 0;
         end else begin
            eer = 1'b1;
         end
      end
      ev = m_act;
      ea = (m_s + m_k) % TOTAL;
      ed = m_act ? word(ea) : 0;
   endtask

   vec_t tbl[$];

   initial begin
      bit ev, edn, eer;
      int ed, ea;

      // Reset held with a start request pending: nothing may happen.
      rst_n = 1'b0;
      drive(1, 1, 0, 3, 1);
      repeat (2) begin
         tick();
         check_out("reset", 0, 0, 0, 0, 0);
      end
      rst_n = 1'b1;
      drive(1, 0, 0, 3, 1);
      tick();
      check_out("post_reset", 0, 0, 0, 0, 0);

      tbl.push_back('{1, 1,  0, 3, 1,  1, 128,  0, 0, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  1, 138,  1, 0, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  1, 148,  2, 0, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  0,   0,  0, 1, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  0,   0,  0, 0, 0});
      tbl.push_back('{1, 1, 22, 4, 1,  1,  92, 22, 0, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  1, 102, 23, 0, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  1, 128,  0, 0, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  1, 138,  1, 0, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  0,   0,  0, 1, 0});
      tbl.push_back('{1, 1, 24, 1, 1,  0,   0,  0, 0, 1});
      tbl.push_back('{1, 0,  0, 0, 1,  0,   0,  0, 0, 0});
      tbl.push_back('{0, 1,  3, 1, 1,  0,   0,  0, 0, 0});
      tbl.push_back('{0, 1, 30, 1, 1,  0,   0,  0, 0, 0});
      tbl.push_back('{1, 1, 10, 1, 0,  1, 228, 10, 0, 0});
      tbl.push_back('{1, 1,  3, 1, 1,  0,   0,  0, 1, 0});
      tbl.push_back('{1, 1, 11, 1, 0,  1, 238, 11, 0, 0});
      tbl.push_back('{1, 0,  0, 0, 1,  0,   0,  0, 1, 0});
      tbl.push_back('{1, 1, 31, 2, 1,  0,   0,  0, 0, 1});
      tbl.push_back('{1, 0,  0, 0, 0,  0,   0,  0, 0, 0});

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].cs, tbl[i].start, tbl[i].addr, tbl[i].len, tbl[i].ready);
         tick();
         check_out($sformatf("vec%0d", i), tbl[i].e_valid, tbl[i].e_data, tbl[i].e_addr,
                   tbl[i].e_done, tbl[i].e_err);
      end

      // Consumer stalls on the first word; data and address must hold.
      drive(1, 1, 5, 2, 0);
      tick();
      check_out("stall.load", 1, 178, 5, 0, 0);
      drive(1, 0, 0, 0, 0);
      repeat (3) begin
         tick();
         check_out("stall.hold", 1, 178, 5, 0, 0);
      end
      drive(1, 0, 0, 0, 1);
      tick();
      check_out("stall.w2", 1, 188, 6, 0, 0);
      tick();
      check_out("stall.done", 0, 0, 0, 1, 0);
      tick();
      check_out("stall.idle", 0, 0, 0, 0, 0);

      // burst_len=0 means 16 words; deselect after the 4th handshake aborts without done.
      drive(1, 1, 0, 0, 1);
      tick();
      check_out("abort.w0", 1, 128, 0, 0, 0);
      drive(1, 0, 0, 0, 1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check_out($sformatf("abort.w%0d", k), 1, word(k), k, 0, 0);
      end
      drive(0, 0, 0, 0, 1);
      tick();
      check_out("abort.cut", 0, 0, 0, 0, 0);
      tick();
      check_out("abort.after", 0, 0, 0, 0, 0);

      // Full 16-word burst crossing the wrap point.
      drive(1, 1, 20, 0, 1);
      tick();
      check_out("full.w0", 1, word(20), 20, 0, 0);
      drive(1, 0, 0, 0, 1);
      for (int k = 1; k < 16; k++) begin
         tick();
         check_out($sformatf("full.w%0d", k), 1, word((20 + k) % TOTAL), (20 + k) % TOTAL, 0, 0);
      end
      tick();
      check_out("full.done", 0, 0, 0, 1, 0);

      // Randomized traffic against the reference model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bit r_rst, r_cs, r_start, r_ready;
         int r_addr, r_len;
         r_rst   = (cyc < 2) || ($urandom_range(0, 99) == 0);
         r_cs    = ($urandom_range(0, 19) != 0);
         r_start = ($urandom_range(0, 2) == 0);
         r_addr  = $urandom_range(0, 27);
         r_len   = $urandom_range(0, 15);
         r_ready = ($urandom_range(0, 9) < 7);
         rst_n   = !r_rst;
         drive(r_cs, r_start, r_addr, r_len, r_ready);
         model_step(r_rst, r_cs, r_start, r_addr, r_len, r_ready, ev, ed, ea, edn, eer);
         tick();
         check_out($sformatf("rnd%0d", cyc), ev, ed, ea, edn, eer);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end
endmodule
